// File: rtl/pipelined_shift_unit.sv
// rtl/pipelined_shift_unit.sv - pipelined multi-mode log shifter with valid/ready and tag
//
// Purpose: SRL / SRA / SHL / ROR / ROL / PASS on a WIDTH-bit operand. The shift is
// split into SH_W register stages; stage k applies a shift of 2^k when amount bit k
// is set. Stage 0 is loaded at accept with the prepared operand already shifted by
// bit 0, so a result is presented SH_W-1 edges after the accepting edge.
// The whole pipe stalls while a presented result is not taken.
//
// Optional feature: define SHIFT_FLAGS_EN to add zero_flag and carry_out.
//
// Ports:
//   clock, reset        rising-edge clock, synchronous active-high reset
//   in_valid, in_ready  input handshake (in_ready is combinational)
//   op                  000 SRL, 001 SRA, 010 SHL, 011 ROR, 100 ROL, others PASS
//   A, B, in_tag        operand, unsigned shift amount, sideband tag
//   out_valid, out_ready output handshake
//   result, out_tag     shifted value and its tag
//   zero_flag, carry_out (SHIFT_FLAGS_EN only) result == 0, last bit shifted out
module pipelined_shift_unit #(
  parameter int WIDTH = 32,
  parameter int AMT_W = 32,
  parameter int TAG_W = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [AMT_W-1:0] B,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
`ifdef SHIFT_FLAGS_EN
  output logic             zero_flag,
  output logic             carry_out,
`endif
  output logic [TAG_W-1:0] out_tag
);

  localparam int SH_W = $clog2(WIDTH);

  localparam logic [2:0] OP_SRL = 3'b000;
  localparam logic [2:0] OP_SRA = 3'b001;
  localparam logic [2:0] OP_SHL = 3'b010;
  localparam logic [2:0] OP_ROR = 3'b011;
  localparam logic [2:0] OP_ROL = 3'b100;

  // One conditional step of a given power-of-two size. SRA relies on the sign bit
  // staying in the MSB after every earlier arithmetic step.
  function automatic logic [WIDTH-1:0] step(input logic [2:0] o,
                                            input logic [WIDTH-1:0] x,
                                            input int s);
    logic [WIDTH-1:0] r;
    case (o)
      OP_SRL:  r = x >> s;
      OP_SRA:  r = $signed(x) >>> s;
      OP_SHL:  r = x << s;
      OP_ROR:  r = (x >> s) | (x << (WIDTH - s));
      OP_ROL:  r = (x << s) | (x >> (WIDTH - s));
      default: r = x;
    endcase
    return r;
  endfunction

  // Pipeline state. op/amount are only needed by the stages that still shift.
  logic             st_valid [SH_W];
  logic [WIDTH-1:0] st_data  [SH_W];
  logic [TAG_W-1:0] st_tag   [SH_W];
  logic [2:0]       st_op    [SH_W-1];
  logic [SH_W-1:0]  st_amt   [SH_W-1];

  logic en;
  assign en       = !(out_valid && !out_ready);
  assign in_ready = en;

  // Operand preparation at accept.
  logic [AMT_W-1:0] b_hi;
  logic             ovf;
  logic             is_rot;
  logic [SH_W-1:0]  amt_raw;
  logic [SH_W-1:0]  prep_amt;
  logic [WIDTH-1:0] prep_data;

  always_comb begin
    b_hi      = B >> SH_W;
    // WIDTH is a power of two, so B >= WIDTH exactly when a bit above SH_W-1 is set.
    ovf       = |b_hi;
    amt_raw   = B[SH_W-1:0];
    is_rot    = (op == OP_ROR) || (op == OP_ROL);
    prep_amt  = amt_raw;
    prep_data = A;
    if (op > OP_ROL) begin
      prep_amt = '0;
    end else if (!is_rot && ovf) begin
      prep_amt  = '0;
      prep_data = (op == OP_SRA) ? {WIDTH{A[WIDTH-1]}} : '0;
    end
  end

`ifdef SHIFT_FLAGS_EN
  logic             st_carry [SH_W];
  logic             prep_carry;
  logic             b_is_w;
  logic [SH_W-1:0]  amt_m1;
  logic [SH_W-1:0]  amt_neg;

  // Last bit shifted out. For rotates this equals result MSB (ROR) or LSB (ROL),
  // which map back to A[amt-1] and A[WIDTH-amt].
  always_comb begin
    b_is_w     = (b_hi == AMT_W'(1)) && (amt_raw == '0);
    amt_m1     = amt_raw - 1'b1;
    amt_neg    = '0 - amt_raw;
    prep_carry = 1'b0;
    if (ovf && !is_rot && (op <= OP_SHL)) begin
      case (op)
        OP_SRA:  prep_carry = A[WIDTH-1];
        OP_SRL:  prep_carry = b_is_w ? A[WIDTH-1] : 1'b0;
        default: prep_carry = b_is_w ? A[0] : 1'b0;
      endcase
    end else if ((op <= OP_ROL) && (amt_raw != '0)) begin
      case (op)
        OP_SHL, OP_ROL: prep_carry = A[amt_neg];
        default:        prep_carry = A[amt_m1];
      endcase
    end
  end

  assign carry_out = st_carry[SH_W-1];
  assign zero_flag = (result == '0);
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int k = 0; k < SH_W; k++) begin
        st_valid[k] <= 1'b0;
        st_data[k]  <= '0;
        st_tag[k]   <= '0;
`ifdef SHIFT_FLAGS_EN
        st_carry[k] <= 1'b0;
`endif
      end
      for (int k = 0; k < SH_W - 1; k++) begin
        st_op[k]  <= '0;
        st_amt[k] <= '0;
      end
    end else if (en) begin
      st_valid[0] <= in_valid;
      st_data[0]  <= prep_amt[0] ? step(op, prep_data, 1) : prep_data;
      st_tag[0]   <= in_tag;
      st_op[0]    <= op;
      st_amt[0]   <= prep_amt;
`ifdef SHIFT_FLAGS_EN
      st_carry[0] <= prep_carry;
`endif
      for (int k = 1; k < SH_W; k++) begin
        st_valid[k] <= st_valid[k-1];
        st_data[k]  <= st_amt[k-1][k] ? step(st_op[k-1], st_data[k-1], 1 << k)
                                      : st_data[k-1];
        st_tag[k]   <= st_tag[k-1];
`ifdef SHIFT_FLAGS_EN
        st_carry[k] <= st_carry[k-1];
`endif
        if (k < SH_W - 1) begin
          st_op[k]  <= st_op[k-1];
          st_amt[k] <= st_amt[k-1];
        end
      end
    end
  end

  assign out_valid = st_valid[SH_W-1];
  assign result    = st_data[SH_W-1];
  assign out_tag   = st_tag[SH_W-1];

endmodule
